// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: assembles DATA_BITS+1 serial bits into a word with a one-deep valid/ready output.
// Optional macro SER_PARITY_EN adds a trailing even-parity bit per word and drives parity_err.
module shift_deser #(
  parameter int unsigned DATA_BITS       = 16,
  parameter int unsigned DATA_COUNT_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 msb_first,
  input  logic                 sin,
  input  logic                 sin_valid,
  output logic [DATA_BITS:0]   Q,
  output logic                 q_valid,
  input  logic                 q_ready,
  output logic                 busy,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int unsigned W = DATA_BITS + 1;
  localparam logic [DATA_COUNT_BITS-1:0] LAST = DATA_COUNT_BITS'(DATA_BITS);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t                     state, state_nx;
  logic [DATA_COUNT_BITS-1:0] count, count_nx;
  logic [W-1:0]               sr, sr_nx;
  logic                       msb, msb_nx;
  logic                       deliver_c;
  logic [W-1:0]               word_c;
  logic                       busy_nx;
`ifdef SER_PARITY_EN
  logic                       perr_c;
`endif

  function automatic logic [W-1:0] shift_in(input logic [W-1:0] cur, input logic b,
                                            input logic mf);
    if (mf) return {cur[W-2:0], b};
    else    return {b, cur[W-1:1]};
  endfunction

  // Framing state, bit counter, shift register and latched bit order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      sr    <= '0;
      msb   <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      sr    <= sr_nx;
      msb   <= msb_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    sr_nx     = sr;
    msb_nx    = msb;
    deliver_c = 1'b0;
    word_c    = sr;
`ifdef SER_PARITY_EN
    perr_c    = 1'b0;
`endif
    if (start) begin
      // Resync: drop any partial word; a bit sampled with start is bit 0 of the new word
      state_nx = SHIFT;
      msb_nx   = msb_first;
      count_nx = '0;
      sr_nx    = '0;
      if (sin_valid) begin
        sr_nx    = shift_in('0, sin, msb_first);
        count_nx = DATA_COUNT_BITS'(1);
      end
    end else begin
      case (state)
        SHIFT: begin
          if (sin_valid) begin
            sr_nx = shift_in(sr, sin, msb);
            if (count == LAST) begin
              count_nx = '0;
`ifdef SER_PARITY_EN
              state_nx = PAR;
`else
              deliver_c = 1'b1;
              word_c    = sr_nx;
`endif
            end else begin
              count_nx = count + 1'b1;
            end
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          if (sin_valid) begin
            deliver_c = 1'b1;
            perr_c    = ^{sr, sin};
            state_nx  = SHIFT;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef SER_PARITY_EN
  assign busy_nx = ((state_nx == SHIFT) && (count_nx != '0)) || (state_nx == PAR);
`else
  assign busy_nx = (state_nx == SHIFT) && (count_nx != '0);
`endif

  // Output word buffer with handshake and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
      busy    <= 1'b0;
    end else begin
      busy <= busy_nx;
      if (start) overrun <= 1'b0;
      if (deliver_c) begin
        if (!q_valid || q_ready) begin
          Q       <= word_c;
          q_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      parity_err <= 1'b0;
    else if (deliver_c && (!q_valid || q_ready))
      parity_err <= perr_c;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser: reset, bit order, streaming, overrun, resync, and parity when SER_PARITY_EN is set.
module tb_shift_deser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, msb_first, sin, sin_valid, q_ready;
  logic [16:0] q;
  logic        q_valid, busy, overrun, parity_err;

  int errors = 0;
  int checks = 0;

`ifdef SER_PARITY_EN
  bit par_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  shift_deser dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msb_first(msb_first),
    .sin(sin), .sin_valid(sin_valid), .Q(q), .q_valid(q_valid),
    .q_ready(q_ready), .busy(busy), .overrun(overrun), .parity_err(parity_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send bits w[hi] down to w[lo]; start accompanies the first bit when do_start is set
  task automatic send_bits(input logic [16:0] w, input int hi, input int lo,
                           input bit do_start, input bit mf, input bit gaps);
    for (int i = hi; i >= lo; i--) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) tick();
      end
      sin       = w[i];
      sin_valid = 1'b1;
      start     = do_start && (i == hi);
      msb_first = mf;
      tick();
      sin_valid = 1'b0;
      start     = 1'b0;
    end
  endtask

  task automatic send_par(input logic [16:0] w);
`ifdef SER_PARITY_EN
    sin       = (^w) ^ par_flip;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
`else
    if (w === 17'hx) $display("note: unknown word");
`endif
  endtask

  task automatic send_word(input logic [16:0] w, input bit do_start, input bit mf,
                           input bit gaps);
    send_bits(w, 16, 0, do_start, mf, gaps);
    send_par(w);
  endtask

  task automatic consume();
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; msb_first = 1'b0; sin = 1'b0;
    sin_valid = 1'b0; q_ready = 1'b0;
    #3;
    check("rst_q", 32'(q), 32'h0);
    check("rst_q_valid", 32'(q_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // sin_valid without start is ignored in IDLE
    for (int i = 0; i < 20; i++) begin
      sin = i[0]; sin_valid = 1'b1; tick();
    end
    sin_valid = 1'b0;
    check("idle_q_valid", 32'(q_valid), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);

    // MSB-first
    send_bits(17'h1A5C3, 16, 1, 1'b1, 1'b1, 1'b0);
    check("msb_pre_valid", 32'(q_valid), 32'h0);
    check("msb_pre_busy", 32'(busy), 32'h1);
    send_bits(17'h1A5C3, 0, 0, 1'b0, 1'b1, 1'b0);
    send_par(17'h1A5C3);
    check("msb_valid", 32'(q_valid), 32'h1);
    check("msb_q", 32'(q), 32'h1A5C3);
    check("msb_busy", 32'(busy), 32'h0);
    consume();
    check("msb_consumed", 32'(q_valid), 32'h0);

    // LSB-first with the same bit sequence
    send_word(17'h1A5C3, 1'b1, 1'b0, 1'b0);
    check("lsb_valid", 32'(q_valid), 32'h1);
    check("lsb_q", 32'(q), 32'h1874B);
    consume();

    // Back-to-back with q_ready held high, gaps in the second word
    q_ready = 1'b1;
    send_word(17'h0F0F0, 1'b1, 1'b1, 1'b0);
    check("b2b_a_valid", 32'(q_valid), 32'h1);
    check("b2b_a_q", 32'(q), 32'h0F0F0);
    send_bits(17'h15555, 16, 16, 1'b0, 1'b1, 1'b0);
    check("b2b_a_pulse", 32'(q_valid), 32'h0);
    send_bits(17'h15555, 15, 0, 1'b0, 1'b1, 1'b1);
    send_par(17'h15555);
    check("b2b_b_valid", 32'(q_valid), 32'h1);
    check("b2b_b_q", 32'(q), 32'h15555);
    check("b2b_overrun", 32'(overrun), 32'h0);
    tick();
    check("b2b_b_pulse", 32'(q_valid), 32'h0);
    q_ready = 1'b0;

    // Overrun: second word dropped while the first is held
    send_word(17'h0ABCD, 1'b1, 1'b1, 1'b0);
    check("ovr_first_q", 32'(q), 32'h0ABCD);
    check("ovr_first_flag", 32'(overrun), 32'h0);
    send_word(17'h1FFFF, 1'b0, 1'b1, 1'b0);
    check("ovr_q_held", 32'(q), 32'h0ABCD);
    check("ovr_valid_held", 32'(q_valid), 32'h1);
    check("ovr_set", 32'(overrun), 32'h1);
    start = 1'b1; tick(); start = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);
    check("ovr_q_after_start", 32'(q), 32'h0ABCD);
    consume();

    // Resync after 9 bits of a word
    send_bits(17'h1FFFF, 16, 8, 1'b1, 1'b1, 1'b0);
    check("resync_busy", 32'(busy), 32'h1);
    check("resync_no_valid", 32'(q_valid), 32'h0);
    send_word(17'h00FFF, 1'b1, 1'b1, 1'b0);
    check("resync_valid", 32'(q_valid), 32'h1);
    check("resync_q", 32'(q), 32'h00FFF);

`ifdef SER_PARITY_EN
    consume();
    send_bits(17'h00001, 16, 0, 1'b1, 1'b1, 1'b0);
    check("par_wait_valid", 32'(q_valid), 32'h0);
    check("par_wait_busy", 32'(busy), 32'h1);
    sin = 1'b1; sin_valid = 1'b1; tick(); sin_valid = 1'b0;
    check("par_good_q", 32'(q), 32'h00001);
    check("par_good_err", 32'(parity_err), 32'h0);
    consume();
    send_bits(17'h00001, 16, 0, 1'b0, 1'b1, 1'b0);
    sin = 1'b0; sin_valid = 1'b1; tick(); sin_valid = 1'b0;
    check("par_bad_valid", 32'(q_valid), 32'h1);
    check("par_bad_q", 32'(q), 32'h00001);
    check("par_bad_err", 32'(parity_err), 32'h1);
`endif

    // Asynchronous reset mid-word while a word is held
    send_bits(17'h1FFFF, 16, 12, 1'b0, 1'b1, 1'b0);
    check("midrst_pre_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q", 32'(q), 32'h0);
    check("midrst_q_valid", 32'(q_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    check("midrst_parity_err", 32'(parity_err), 32'h0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sin = 1'b1; sin_valid = 1'b1; tick();
    end
    sin_valid = 1'b0;
    check("midrst_idle_valid", 32'(q_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
